cpu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the 8-bit accumulator CPU. It steps each instruction through fetch, decode, memory and write-back, and drives the load enables of the PC, IR, MDR and ACC registers. It owns the single shared memory port through a req/ready handshake. It also counts retired instructions and halts on HLT or on a memory timeout.

---
 rtl/cpu_ctrl_pkg.sv | 27 ++
 rtl/ctrl_state_reg.sv | 26 ++
 rtl/cpu_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state, opcode and ALU encodings for the accumulator CPU sequencer
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/ctrl_state_reg.sv
// rtl/ctrl_state_reg.sv - sequencer state register and latched opcode
module ctrl_state_reg
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  state_e     state_d,
  input  logic       op_en,
  input  logic [3:0] op_d,
  output state_e     state_q,
  output logic [3:0] op_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      if (op_en) begin
        op_q <= op_d;
      end
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/mem/write-back sequencer
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             acc_load,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic              op_en;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic              bus_err_q, bus_err_d;
  logic              timeout_hit;

  ctrl_state_reg u_state_reg (
    .clk     (CLK),
    .rst     (RST),
    .state_d (state_d),
    .op_en   (op_en),
    .op_d    (opcode),
    .state_q (state_q),
    .op_q    (op_q)
  );

  // The limit cycle only errors if ready is still low; ready in that cycle completes the transfer.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    op_en       = 1'b0;
    instr_cnt_d = instr_cnt_q;
    bus_err_d   = bus_err_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    ir_load     = 1'b0;
    mdr_load    = 1'b0;
    acc_load    = 1'b0;
    alu_op      = ALU_PASS;
    halted      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          if (instr_cnt_q != '1) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
          end
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        op_en = 1'b1;
        case (opcode)
          OP_NOP:                         state_d = ST_FETCH;
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = ST_MEM;
          OP_JMP, OP_JZ:                  state_d = ST_EXEC;
          OP_HLT:                         state_d = ST_HALT;
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        if (op_q == OP_JMP) begin
          pc_load = 1'b1;
        end else if (op_q == OP_JZ) begin
          pc_load = zero;
        end
        state_d = ST_FETCH;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op_q == OP_STA);
        if (mem_ready) begin
          if (op_q == OP_STA) begin
            state_d = ST_FETCH;
          end else begin
            mdr_load = 1'b1;
            state_d  = ST_WB;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        acc_load = 1'b1;
        case (op_q)
          OP_ADD:  alu_op = ALU_ADD;
          OP_SUB:  alu_op = ALU_SUB;
          default: alu_op = ALU_PASS;
        endcase
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase

    // Any state change restarts the wait count, so each new request starts from zero.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q  <= '0;
      instr_cnt_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign state     = state_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_load;
  logic        mdr_load, acc_load, halted, bus_err, illegal;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] instr_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  cpu_ctrl_fsm #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .ir_load   (ir_load),
    .mdr_load  (mdr_load),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .halted    (halted),
    .bus_err   (bus_err),
    .illegal   (illegal),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Precondition: mid-cycle in FETCH. Leaves the FSM mid-cycle in DECODE with opcode driven.
  task automatic fetch_op(input logic [3:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    chk("fetch_ir_load", ir_load, 1);
    chk("fetch_pc_inc", pc_inc, 1);
    tick();
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    RST = 1'b0;
    #1;
    chk("idle_state", state, 0);
    chk("idle_instr_cnt", instr_cnt, 0);
    chk("idle_bus_err", bus_err, 0);
    chk("idle_halted", halted, 0);

    // NOP loop with memory always ready
    start = 1'b1; mem_ready = 1'b1; opcode = 4'h0;
    #1;
    chk("idle_ignores_ready", ir_load, 0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("nop_state", state, (i % 2 == 0) ? 1 : 2);
      chk("nop_ir_load", ir_load, (i % 2 == 0) ? 1 : 0);
      chk("nop_mem_req", mem_req, (i % 2 == 0) ? 1 : 0);
      tick();
    end
    chk("nop_instr_cnt", instr_cnt, 3);
    chk("nop_back_fetch", state, 1);

    // LDA with ready delayed three cycles in MEM
    fetch_op(4'h1);
    mem_ready = 1'b0;
    #1;
    chk("lda_decode", state, 2);
    chk("lda_no_illegal", illegal, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      chk("lda_mem_state", state, 4);
      chk("lda_mem_req", mem_req, 1);
      chk("lda_addr_sel", addr_sel, 1);
      chk("lda_mem_we", mem_we, 0);
      chk("lda_mdr_load", mdr_load, (i == 3) ? 1 : 0);
      tick();
    end
    chk("lda_wb_state", state, 5);
    chk("lda_acc_load", acc_load, 1);
    chk("lda_alu_op", alu_op, 0);
    chk("lda_wb_mem_req", mem_req, 0);
    tick();
    chk("lda_to_fetch", state, 1);

    // STA writes and skips WB
    fetch_op(4'h2);
    tick();
    chk("sta_mem_state", state, 4);
    chk("sta_mem_we", mem_we, 1);
    chk("sta_addr_sel", addr_sel, 1);
    chk("sta_mdr_load", mdr_load, 0);
    chk("sta_acc_load", acc_load, 0);
    tick();
    chk("sta_to_fetch", state, 1);

    // ADD and SUB select their ALU op in WB
    fetch_op(4'h3);
    tick();
    chk("add_mdr_load", mdr_load, 1);
    tick();
    chk("add_acc_load", acc_load, 1);
    chk("add_alu_op", alu_op, 1);
    tick();
    fetch_op(4'h4);
    tick();
    tick();
    chk("sub_state", state, 5);
    chk("sub_alu_op", alu_op, 2);
    tick();

    // JZ not taken, JZ taken, JMP with zero clear
    fetch_op(4'h6);
    zero = 1'b0;
    tick();
    chk("jz0_state", state, 3);
    chk("jz0_pc_load", pc_load, 0);
    tick();
    fetch_op(4'h6);
    zero = 1'b1;
    tick();
    chk("jz1_pc_load", pc_load, 1);
    tick();
    fetch_op(4'h5);
    zero = 1'b0;
    tick();
    chk("jmp_pc_load", pc_load, 1);
    tick();

    // Undefined opcode
    fetch_op(4'hA);
    chk("ill_pulse", illegal, 1);
    tick();
    chk("ill_state", state, 1);
    chk("ill_cleared", illegal, 0);
    chk("ill_instr_cnt", instr_cnt, 11);

    // Timeout in FETCH: 15 counted wait cycles then the limit cycle errors
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_wait_state", state, 1);
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_err", bus_err, 0);
      tick();
    end
    chk("to_halt_state", state, 6);
    chk("to_bus_err", bus_err, 1);
    chk("to_halted", halted, 1);
    chk("to_req_drop", mem_req, 0);
    chk("to_instr_cnt", instr_cnt, 11);

    // Ready on the limit cycle completes normally
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst2_bus_err", bus_err, 0);
    chk("rst2_instr_cnt", instr_cnt, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      opcode = 4'hF;
      #1;
      chk("lim_ir_load", ir_load, (i == 15) ? 1 : 0);
      tick();
    end
    chk("lim_decode", state, 2);
    chk("lim_bus_err", bus_err, 0);
    chk("lim_instr_cnt", instr_cnt, 1);
    tick();

    // HLT holds regardless of start
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      mem_ready = 1'b1;
      #1;
      chk("hlt_state", state, 6);
      chk("hlt_halted", halted, 1);
      chk("hlt_req", mem_req, 0);
      tick();
    end
    chk("hlt_bus_err", bus_err, 0);
    start = 1'b0;

    // Reset mid-wait
    RST = 1'b1;
    tick();
    RST = 1'b0; start = 1'b1; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("midrst_wait_req", mem_req, 1);
    RST = 1'b1;
    #1;
    chk("midrst_req_held", mem_req, 1);
    tick();
    chk("midrst_state", state, 0);
    chk("midrst_req_drop", mem_req, 0);
    RST = 1'b0; mem_ready = 1'b1;
    tick();
    chk("idle_ready_state", state, 0);
    chk("idle_ready_cnt", instr_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
